fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined MIPS core, directly downstream of the program counter.
- Takes the current PC and PC+4, issues the instruction-memory read, and handles the ihit handshake.
- Drives PC_EN back to the program counter and loads the IF/ID pipeline register.
- Absorbs hazard-unit stalls with a one-entry hold buffer. Drains in-flight requests on flush and parks on halt.

Parameters:
- CNT_W, 32, width of the fetched-instruction performance counter (saturating).

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- pcaddr  input  32  current PC from the program counter
- nxt_pc  input  32  PC+4 from the program counter
- ihit  input  1  instruction memory data valid this cycle
- iload  input  32  instruction word from memory
- stall  input  1  hazard unit: hold IF/ID
- flush  input  1  branch/jump redirect: squash wrong-path fetch
- halt  input  1  halt seen downstream
- iREN  output  1  instruction read enable
- iaddr  output  32  instruction read address
- PC_EN  output  1  program counter update enable
- ifid_valid  output  1  IF/ID entry valid
- ifid_instr  output  32  IF/ID instruction
- ifid_pc  output  32  IF/ID PC of instruction
- ifid_npc  output  32  IF/ID PC+4
- fetch_count  output  CNT_W  instructions accepted since reset

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=FETCH; ifid_valid=0, ifid_instr/pc/npc=0; hold buffer empty; drain_addr=0; fetch_count=0.
- While nRST=0: iREN=0, PC_EN=0.
- States:
  - FETCH: normal fetching.
  - HOLD: one instruction buffered during a stall.
  - DRAIN: stale request in flight after a flush.
  - HALTED: fetch stopped.
- Priority, every cycle: halt > flush > stall > normal.
- Memory rule: once iREN=1 with an address and no ihit, iaddr must stay stable until ihit.
- FETCH:
  - iREN=1, iaddr=pcaddr (combinational).
  - ihit & !stall: on CLK, ifid_instr<=iload, ifid_pc<=pcaddr, ifid_npc<=nxt_pc, ifid_valid<=1. PC_EN=1 that cycle. Stay in FETCH.
  - ihit & stall: on CLK, capture iload/pcaddr/nxt_pc into the hold buffer; IF/ID unchanged. PC_EN=1. Go to HOLD.
  - !ihit & !stall: ifid_valid<=0 (bubble); other IF/ID fields hold. PC_EN=0.
  - !ihit & stall: IF/ID unchanged. PC_EN=0.
- HOLD:
  - iREN=0, PC_EN=0.
  - !stall: move the hold buffer into IF/ID (ifid_valid<=1); go to FETCH. Latency: instruction enters IF/ID on the first edge with stall=0.
  - stall: everything holds.
- flush (overrides stall):
  - Always: ifid_valid<=0 on CLK, and PC_EN=1 that cycle so the PC loads the redirect target.
  - In FETCH with ihit: data discarded; stay in FETCH.
  - In FETCH without ihit: drain_addr<=pcaddr; go to DRAIN.
  - In HOLD: hold buffer discarded; go to FETCH.
  - In DRAIN: PC_EN=1, stay in DRAIN. drain_addr is unchanged because the request is still in flight.
- DRAIN:
  - iREN=1, iaddr=drain_addr, PC_EN=0 (except on flush, as above).
  - ihit: data discarded; go to FETCH.
  - ifid_valid<=0 every cycle in DRAIN.
- HALTED (entered from any state on halt):
  - iREN=0, PC_EN=0, ifid_valid<=0.
  - In-flight request or hold buffer dropped.
  - Exit only by reset.
- fetch_count:
  - +1 on every edge where an instruction is accepted into IF/ID or the hold buffer (ihit in FETCH with no flush/halt).
  - Saturates at all-ones.
  - Not incremented on HOLD->IF/ID transfer or on discarded data.
- Reset mid-operation: asynchronous return to reset values regardless of state. A pending memory request is abandoned.

Test Plan:
- Reset then ihit=1 every cycle, pcaddr 0x0,0x4,0x8, iload 0x20010005.. -> PC_EN=1 each cycle; ifid_valid=1 from the first edge; ifid_pc tracks pcaddr one cycle late; fetch_count=3.
- ihit delayed 3 cycles at pcaddr=0x10 -> iREN=1, iaddr=0x10 held, PC_EN=0, ifid_valid=0 for 3 cycles; on ihit ifid_pc=0x10, ifid_npc=0x14.
- stall=1 asserted with ihit at pcaddr=0x20 for 2 cycles -> PC_EN=1 once, state HOLD, iREN=0, IF/ID unchanged; stall drops -> ifid_pc=0x20 next edge; fetch_count +1 only.
- flush with no ihit at pcaddr=0x30, pcaddr then becomes 0x100 -> PC_EN=1 one cycle, iaddr stays 0x30 until ihit; data discarded; next fetch iaddr=0x100; ifid_valid=0 throughout.
- flush and stall together while in HOLD -> buffer discarded, ifid_valid=0, state FETCH; flush and ihit same cycle -> ifid_valid=0, fetch_count unchanged.
- halt during pending request -> iREN=0, PC_EN=0 permanently; nRST pulse mid-fetch -> all outputs at reset values immediately, fetch resumes after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage - issues imem reads (iREN/iaddr), gates PC_EN, loads IF/ID (ifid_*), buffers one instr on stall, drains on flush, parks on halt, counts fetches (fetch_count)
module fetch_stage #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      pcaddr,
  input  logic [31:0]      nxt_pc,
  input  logic             ihit,
  input  logic [31:0]      iload,
  input  logic             stall,
  input  logic             flush,
  input  logic             halt,
  output logic             iREN,
  output logic [31:0]      iaddr,
  output logic             PC_EN,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_npc,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;
  state_t state, next_state;
  logic [31:0] hold_instr, hold_pc, hold_npc, drain_addr;
  logic ren, pc_en, ld_mem, ld_buf, cap_buf, kill, set_drain, cnt_en;
  always_comb begin
    next_state = state;
    ren = 1'b0;
    pc_en = 1'b0;
    ld_mem = 1'b0;
    ld_buf = 1'b0;
    cap_buf = 1'b0;
    kill = 1'b0;
    set_drain = 1'b0;
    cnt_en = 1'b0;
    if (halt) begin
      next_state = HALTED;
      kill = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          ren = 1'b1;
          pc_en = ihit | flush;
          if (flush) begin
            kill = 1'b1;
            set_drain = !ihit;
            next_state = ihit ? FETCH : DRAIN;
          end else if (ihit) begin
            cnt_en = 1'b1;
            cap_buf = stall;
            ld_mem = !stall;
            next_state = stall ? HOLD : FETCH;
          end else begin
            kill = !stall;
          end
        end
        HOLD: begin
          pc_en = flush;
          kill = flush;
          ld_buf = !flush && !stall;
          next_state = (flush || !stall) ? FETCH : HOLD;
        end
        DRAIN: begin
          ren = 1'b1;
          pc_en = flush;
          kill = 1'b1;
          next_state = ihit ? FETCH : DRAIN;
        end
        default: kill = 1'b1;
      endcase
    end
  end
  assign iREN  = ren & nRST;
  assign PC_EN = pc_en & nRST;
  assign iaddr = (state == DRAIN) ? drain_addr : pcaddr;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc <= '0;
      ifid_npc <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
      hold_npc <= '0;
      drain_addr <= '0;
      fetch_count <= '0;
    end else begin
      state <= next_state;
      if (kill) ifid_valid <= 1'b0;
      if (ld_mem) begin
        ifid_valid <= 1'b1;
        ifid_instr <= iload;
        ifid_pc <= pcaddr;
        ifid_npc <= nxt_pc;
      end
      if (ld_buf) begin
        ifid_valid <= 1'b1;
        ifid_instr <= hold_instr;
        ifid_pc <= hold_pc;
        ifid_npc <= hold_npc;
      end
      if (cap_buf) begin
        hold_instr <= iload;
        hold_pc <= pcaddr;
        hold_npc <= nxt_pc;
      end
      if (set_drain) drain_addr <= pcaddr;
      if (cnt_en && !(&fetch_count)) fetch_count <= fetch_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam int CW = 4;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [31:0] pcaddr = '0, nxt_pc = '0, iload = '0;
  logic ihit = 1'b0, stall = 1'b0, flush = 1'b0, halt = 1'b0;
  logic iREN, PC_EN, ifid_valid;
  logic [31:0] iaddr, ifid_instr, ifid_pc, ifid_npc;
  logic [CW-1:0] fetch_count;
  int checks = 0, errors = 0;
  bit m_halt, m_held, m_drain, m_valid;
  logic [31:0] m_daddr, m_instr, m_pc, m_npc, h_instr, h_pc, h_npc;
  int m_count;
  logic c_ren, c_pcen, e_ren, e_pcen;
  logic [31:0] c_addr, e_addr;

  fetch_stage #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .pcaddr(pcaddr), .nxt_pc(nxt_pc), .ihit(ihit), .iload(iload),
    .stall(stall), .flush(flush), .halt(halt), .iREN(iREN), .iaddr(iaddr), .PC_EN(PC_EN),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_halt = 0; m_held = 0; m_drain = 0; m_valid = 0;
    m_daddr = 0; m_instr = 0; m_pc = 0; m_npc = 0; m_count = 0;
  endtask

  task automatic drive(input logic ih, st, fl, hl, input logic [31:0] pc, ld);
    @(negedge CLK);
    ihit = ih; stall = st; flush = fl; halt = hl; pcaddr = pc; nxt_pc = pc + 32'd4; iload = ld;
    #2;
    c_ren = iREN; c_addr = iaddr; c_pcen = PC_EN;
    e_addr = 0;
    if (m_halt || hl) begin e_ren = 0; e_pcen = 0; end
    else if (m_held) begin e_ren = 0; e_pcen = fl; end
    else if (m_drain) begin e_ren = 1; e_addr = m_daddr; e_pcen = fl; end
    else begin e_ren = 1; e_addr = pc; e_pcen = ih | fl; end
    @(posedge CLK);
    if (hl) begin
      m_halt = 1; m_held = 0; m_drain = 0; m_valid = 0;
    end else if (m_halt) m_valid = 0;
    else if (m_held) begin
      if (fl) begin m_held = 0; m_valid = 0; end
      else if (!st) begin m_held = 0; m_valid = 1; m_instr = h_instr; m_pc = h_pc; m_npc = h_npc; end
    end else if (m_drain) begin
      m_valid = 0;
      if (ih) m_drain = 0;
    end else if (fl) begin
      m_valid = 0;
      if (!ih) begin m_drain = 1; m_daddr = pc; end
    end else if (ih) begin
      m_count = (m_count == (1 << CW) - 1) ? m_count : m_count + 1;
      if (st) begin m_held = 1; h_instr = ld; h_pc = pc; h_npc = pc + 4; end
      else begin m_valid = 1; m_instr = ld; m_pc = pc; m_npc = pc + 4; end
    end else if (!st) m_valid = 0;
    #1;
  endtask

  task automatic go_reset();
    @(negedge CLK);
    #2;
    nRST = 0; ihit = 1; stall = 0; flush = 0; halt = 0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge CLK);
    nRST = 1; ihit = 0;
  endtask

  task automatic test_reset();
    go_reset();
    checks++; if (iREN !== 1'b0 || PC_EN !== 1'b0) begin errors++; $display("FAIL reset_en iREN=%b PC_EN=%b want 0 0", iREN, PC_EN); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 0 || ifid_pc !== 0 || ifid_npc !== 0) begin errors++; $display("FAIL reset_ifid v=%b i=%h pc=%h npc=%h want zeros", ifid_valid, ifid_instr, ifid_pc, ifid_npc); end
    checks++; if (fetch_count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    release_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'(i * 4), 32'h20010005 + 32'(i));
      checks++; if (c_pcen !== 1'b1) begin errors++; $display("FAIL stream_pcen%0d got %b want 1", i, c_pcen); end
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(i * 4) || ifid_instr !== 32'h20010005 + 32'(i)) begin errors++; $display("FAIL stream_ifid%0d v=%b pc=%h i=%h want 1 %h %h", i, ifid_valid, ifid_pc, ifid_instr, i * 4, 32'h20010005 + 32'(i)); end
    end
    checks++; if (fetch_count !== 4'd3) begin errors++; $display("FAIL stream_count got %0d want 3", fetch_count); end
  endtask

  task automatic test_delayed();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'h10, 32'hdead0000);
      checks++; if (c_ren !== 1'b1 || c_addr !== 32'h10 || c_pcen !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL delay_wait%0d ren=%b addr=%h pcen=%b v=%b want 1 10 0 0", i, c_ren, c_addr, c_pcen, ifid_valid); end
    end
    drive(1, 0, 0, 0, 32'h10, 32'h8c220000);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h10 || ifid_npc !== 32'h14 || ifid_instr !== 32'h8c220000) begin errors++; $display("FAIL delay_hit v=%b pc=%h npc=%h i=%h want 1 10 14 8c220000", ifid_valid, ifid_pc, ifid_npc, ifid_instr); end
  endtask

  task automatic test_stall();
    int c0;
    c0 = m_count;
    drive(1, 1, 0, 0, 32'h20, 32'haaaa0020);
    checks++; if (c_pcen !== 1'b1 || ifid_pc !== 32'h10) begin errors++; $display("FAIL stall_capture pcen=%b ifid_pc=%h want 1 10", c_pcen, ifid_pc); end
    drive(1, 1, 0, 0, 32'h24, 32'hbbbb0024);
    checks++; if (c_ren !== 1'b0 || c_pcen !== 1'b0 || ifid_pc !== 32'h10) begin errors++; $display("FAIL stall_hold ren=%b pcen=%b ifid_pc=%h want 0 0 10", c_ren, c_pcen, ifid_pc); end
    drive(0, 0, 0, 0, 32'h24, 32'h0);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h20 || ifid_npc !== 32'h24 || ifid_instr !== 32'haaaa0020) begin errors++; $display("FAIL stall_release v=%b pc=%h npc=%h i=%h want 1 20 24 aaaa0020", ifid_valid, ifid_pc, ifid_npc, ifid_instr); end
    checks++; if (fetch_count !== CW'(c0 + 1)) begin errors++; $display("FAIL stall_count got %0d want %0d", fetch_count, c0 + 1); end
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 0, 32'h30, 32'h0);
    checks++; if (c_pcen !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_pcen pcen=%b v=%b want 1 0", c_pcen, ifid_valid); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 32'h100, 32'h0);
      checks++; if (c_ren !== 1'b1 || c_addr !== 32'h30 || c_pcen !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_drain%0d ren=%b addr=%h pcen=%b v=%b want 1 30 0 0", i, c_ren, c_addr, c_pcen, ifid_valid); end
    end
    drive(1, 0, 0, 0, 32'h100, 32'hbad00bad);
    checks++; if (c_addr !== 32'h30 || ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_discard addr=%h v=%b want 30 0", c_addr, ifid_valid); end
    drive(0, 0, 0, 0, 32'h100, 32'h0);
    checks++; if (c_ren !== 1'b1 || c_addr !== 32'h100) begin errors++; $display("FAIL flush_resume ren=%b addr=%h want 1 100", c_ren, c_addr); end
  endtask

  task automatic test_flush_hold();
    int c0;
    drive(1, 1, 0, 0, 32'h200, 32'h11112222);
    drive(0, 1, 1, 0, 32'h204, 32'h0);
    checks++; if (c_pcen !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL fhold_flush pcen=%b v=%b want 1 0", c_pcen, ifid_valid); end
    drive(0, 0, 0, 0, 32'h204, 32'h0);
    checks++; if (c_ren !== 1'b1 || c_addr !== 32'h204 || ifid_valid !== 1'b0) begin errors++; $display("FAIL fhold_fetch ren=%b addr=%h v=%b want 1 204 0", c_ren, c_addr, ifid_valid); end
    c0 = m_count;
    drive(1, 0, 1, 0, 32'h300, 32'h33334444);
    checks++; if (ifid_valid !== 1'b0 || fetch_count !== CW'(c0)) begin errors++; $display("FAIL fhit v=%b count=%0d want 0 %0d", ifid_valid, fetch_count, c0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0), 1'b0, $urandom & 32'hfffffffc, $urandom);
      checks++;
      if (c_ren !== e_ren || c_pcen !== e_pcen || (e_ren && c_addr !== e_addr)) begin errors++; $display("FAIL rnd_comb%0d ren=%b pcen=%b addr=%h want %b %b %h", n, c_ren, c_pcen, c_addr, e_ren, e_pcen, e_addr); end
      checks++;
      if (ifid_valid !== m_valid || ifid_instr !== m_instr || ifid_pc !== m_pc || ifid_npc !== m_npc || fetch_count !== CW'(m_count)) begin
        errors++; $display("FAIL rnd_reg%0d v=%b i=%h pc=%h npc=%h cnt=%0d want %b %h %h %h %0d", n, ifid_valid, ifid_instr, ifid_pc, ifid_npc, fetch_count, m_valid, m_instr, m_pc, m_npc, m_count);
      end
    end
    checks++; if (fetch_count !== 4'hf) begin errors++; $display("FAIL rnd_saturate got %0d want 15", fetch_count); end
  endtask

  task automatic test_halt();
    go_reset();
    release_reset();
    drive(0, 0, 0, 0, 32'h40, 32'h0);
    drive(0, 0, 0, 1, 32'h40, 32'h0);
    checks++; if (c_ren !== 1'b0 || c_pcen !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_enter ren=%b pcen=%b v=%b want 0 0 0", c_ren, c_pcen, ifid_valid); end
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'b0, 1'($urandom), 1'b0, 32'h44, $urandom);
      checks++; if (c_ren !== 1'b0 || c_pcen !== 1'b0 || ifid_valid !== 1'b0 || fetch_count !== 0) begin errors++; $display("FAIL halt_park%0d ren=%b pcen=%b v=%b cnt=%0d want 0 0 0 0", i, c_ren, c_pcen, ifid_valid, fetch_count); end
    end
    go_reset();
    release_reset();
    drive(1, 0, 0, 0, 32'h80, 32'h55556666);
    drive(1, 0, 0, 0, 32'h84, 32'h77778888);
    checks++; if (ifid_valid !== 1'b1 || fetch_count !== 4'd2) begin errors++; $display("FAIL pre_reset v=%b cnt=%0d want 1 2", ifid_valid, fetch_count); end
    go_reset();
    checks++; if (iREN !== 1'b0 || PC_EN !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 0 || fetch_count !== 0) begin errors++; $display("FAIL midreset ren=%b pcen=%b v=%b pc=%h cnt=%0d want 0 0 0 0 0", iREN, PC_EN, ifid_valid, ifid_pc, fetch_count); end
    release_reset();
    drive(1, 0, 0, 0, 32'h88, 32'h9999aaaa);
    checks++; if (c_ren !== 1'b1 || c_addr !== 32'h88 || ifid_valid !== 1'b1 || ifid_pc !== 32'h88 || fetch_count !== 4'd1) begin errors++; $display("FAIL resume ren=%b addr=%h v=%b pc=%h cnt=%0d want 1 88 1 88 1", c_ren, c_addr, ifid_valid, ifid_pc, fetch_count); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_delayed();
    test_stall();
    test_flush();
    test_flush_hold();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
